// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin front end that shares one W-bit signed calculator
// datapath between two requesters. It latches the winner's operation, issues it,
// waits ALU_LAT cycles, and captures the result. The result goes back to the
// winner through a valid/ready handshake, and the last completed result is kept
// for display.
module calc_arbiter #(
    parameter int unsigned W       = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    // Requester 0
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    // Requester 1
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    // Shared response payload
    output logic [W:0]   rsp_r,
    output logic         rsp_ovf,
    output logic         rsp_err,
    // Datapath interface
    output logic [2:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W:0]   alu_r,
    input  logic         alu_ovf,
    // Display path
    output logic [W:0]   last_r,
    output logic         last_ovf,
    output logic         last_src,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    localparam logic [2:0] LastCnt = 3'(ALU_LAT - 1);

    state_e       state_q;
    logic         ptr_q;
    logic         gnt_q;
    logic [2:0]   cnt_q;
    logic [2:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W:0]   rsp_r_q;
    logic         rsp_ovf_q;
    logic         rsp_err_q;
    logic         rsp0_valid_q;
    logic         rsp1_valid_q;
    logic [W:0]   last_r_q;
    logic         last_ovf_q;
    logic         last_src_q;

    logic         gnt_d;
    logic         accept;
    logic         rsp_hs;
    logic         op_reserved;

    // Grant selection in IDLE: a lone requester wins; on contention the pointer decides.
    always_comb begin
        gnt_d = 1'b0;
        if (req1_valid && !req0_valid) begin
            gnt_d = 1'b1;
        end else if (req0_valid && req1_valid) begin
            gnt_d = ptr_q;
        end
        accept = (state_q == StIdle) && (req0_valid || req1_valid);
    end

    // Readies are masked by reset so every output reads 0 while RESET_N is low.
    assign req0_ready = RESET_N & accept & ~gnt_d;
    assign req1_ready = RESET_N & accept & gnt_d;

    assign rsp_hs      = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);
    assign op_reserved = (op_q[2:1] == 2'b11);

    // Control FSM with all datapath-facing and response state registered.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            ptr_q        <= 1'b0;
            gnt_q        <= 1'b0;
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_r_q      <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last_r_q     <= '0;
            last_ovf_q   <= 1'b0;
            last_src_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= gnt_d ? req1_op : req0_op;
                        a_q     <= gnt_d ? req1_a  : req0_a;
                        b_q     <= gnt_d ? req1_b  : req0_b;
                        gnt_q   <= gnt_d;
                        ptr_q   <= ~gnt_d;
                        cnt_q   <= '0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (cnt_q == LastCnt) begin
                        cnt_q   <= '0;
                        state_q <= StCapture;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StCapture: begin
                    // Reserved opcodes discard whatever the datapath produced.
                    if (op_reserved) begin
                        rsp_r_q   <= '0;
                        rsp_ovf_q <= 1'b0;
                        rsp_err_q <= 1'b1;
                    end else begin
                        rsp_r_q   <= alu_r;
                        rsp_ovf_q <= alu_ovf;
                        rsp_err_q <= 1'b0;
                    end
                    rsp0_valid_q <= ~gnt_q;
                    rsp1_valid_q <= gnt_q;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (rsp_hs) begin
                        last_r_q     <= rsp_r_q;
                        last_ovf_q   <= rsp_ovf_q;
                        last_src_q   <= gnt_q;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_r      = rsp_r_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_err    = rsp_err_q;
    assign last_r     = last_r_q;
    assign last_ovf   = last_ovf_q;
    assign last_src   = last_src_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: directed scenarios followed by randomized traffic.
// Results are checked against an integer-arithmetic reference model and a
// "last granted" round-robin model.
module tb_calc_arbiter;

    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [4:0] rsp_r;
    logic       rsp_ovf, rsp_err;
    logic [2:0] alu_op;
    logic [3:0] alu_a, alu_b;
    logic [4:0] alu_r;
    logic       alu_ovf;
    logic [4:0] last_r;
    logic       last_ovf, last_src, busy;

    int checks = 0;
    int errors = 0;
    int last_g = -1;

    always #5 clk = ~clk;

    calc_arbiter #(.W(4), .ALU_LAT(LAT)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_r(rsp_r), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_ovf(alu_ovf),
        .last_r(last_r), .last_ovf(last_ovf), .last_src(last_src), .busy(busy)
    );

    // Datapath stand-in: 5-bit sign-extended arithmetic; reserved ops give junk.
    always_comb begin
        logic [4:0] ea, eb;
        ea      = {alu_a[3], alu_a};
        eb      = {alu_b[3], alu_b};
        alu_r   = 5'b10101;
        alu_ovf = 1'b1;
        case (alu_op)
            3'd0: alu_r = ea + eb;
            3'd1: alu_r = eb + ea;
            3'd2: alu_r = ea - eb;
            3'd3: alu_r = eb - ea;
            3'd4: alu_r = ea[4] ? (5'd0 - ea) : ea;
            3'd5: alu_r = eb[4] ? (5'd0 - eb) : eb;
            default: ;
        endcase
        if (alu_op[2:1] != 2'b11) alu_ovf = (alu_r[4] != alu_r[3]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on signed operands.
    task automatic model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         output logic [4:0] r, output logic ovf, output logic err);
        int sa, sb, res;
        sa  = $signed(a);
        sb  = $signed(b);
        res = 0;
        err = 1'b0;
        case (op)
            3'd0, 3'd1: res = sa + sb;
            3'd2: res = sa - sb;
            3'd3: res = sb - sa;
            3'd4: res = (sa < 0) ? -sa : sa;
            3'd5: res = (sb < 0) ? -sb : sb;
            default: err = 1'b1;
        endcase
        if (err) begin
            r   = 5'd0;
            ovf = 1'b0;
        end else begin
            r   = res[4:0];
            ovf = (res > 7) || (res < -8);
        end
    endtask

    function automatic logic rdy(input int idx);
        return (idx == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rspv(input int idx);
        return (idx == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic set_req(input int idx, input logic v, input logic [2:0] op,
                           input logic [3:0] a, input logic [3:0] b);
        if (idx == 1) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic set_valid(input int idx, input logic v);
        if (idx == 1) req1_valid = v;
        else req0_valid = v;
    endtask

    task automatic set_rsp_ready(input int idx, input logic v);
        if (idx == 1) rsp1_ready = v;
        else rsp0_ready = v;
    endtask

    // One full transaction for requester idx; called at a falling edge.
    task automatic run_op(input int idx, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input int hold, input bit raise_other,
                          output int waited);
        logic [4:0] er;
        logic       eo, ee;
        int         cyc;
        model(op, a, b, er, eo, ee);
        set_req(idx, 1'b1, op, a, b);
        #1;
        waited = 0;
        while (rdy(idx) !== 1'b1 && waited < 40) begin
            @(negedge clk); #1; waited++;
        end
        check("req_ready", rdy(idx), 1);
        check("loser_ready", rdy(1 - idx), 0);
        @(negedge clk);
        set_valid(idx, 1'b0);
        if (raise_other) set_valid(1 - idx, 1'b1);
        #1;
        check("busy", busy, 1);
        cyc = 1;
        while (rspv(idx) !== 1'b1 && cyc < 20) begin
            check("ready_while_busy", {req0_ready, req1_ready}, 0);
            @(negedge clk); #1; cyc++;
        end
        check("latency", cyc, LAT + 2);
        check("alu_op", alu_op, op);
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("rsp_r", rsp_r, er);
        check("rsp_ovf", rsp_ovf, eo);
        check("rsp_err", rsp_err, ee);
        check("rsp_other", rspv(1 - idx), 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check("hold_valid", rspv(idx), 1);
            check("hold_data", {rsp_r, rsp_ovf, rsp_err}, {er, eo, ee});
            check("hold_ready", {req0_ready, req1_ready}, 0);
        end
        set_rsp_ready(idx, 1'b1);
        @(negedge clk);
        set_rsp_ready(idx, 1'b0);
        #1;
        check("rsp_drop", rspv(idx), 0);
        check("idle", busy, 0);
        check("last_r", last_r, er);
        check("last_ovf", last_ovf, eo);
        check("last_src", last_src, idx);
        last_g = idx;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_g = -1;
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;

        // Reset state, including a masked ready for a pending request.
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
        check("rst_rsp", {rsp0_valid, rsp1_valid, rsp_r, rsp_ovf, rsp_err}, 0);
        check("rst_last", {last_r, last_ovf, last_src}, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester: 1 + 3.
        run_op(0, 3'b000, 4'd1, 4'd3, 0, 0, w);

        // Contention from reset: req0 first, then req1 right after.
        pulse_reset();
        set_req(1, 1'b1, 3'b000, 4'd7, 4'd1);
        run_op(0, 3'b010, 4'd7, 4'd1, 0, 0, w);
        check("contend0_wait", w, 0);
        run_op(1, 3'b000, 4'd7, 4'd1, 0, 0, w);
        check("contend1_wait", w, 0);

        // ABS edge cases.
        run_op(1, 3'b100, 4'b1000, 4'd0, 0, 0, w);
        run_op(1, 3'b101, 4'd0, 4'b1001, 0, 0, w);

        // Reserved opcodes.
        run_op(0, 3'b110, 4'd3, 4'd3, 0, 0, w);
        run_op(1, 3'b111, 4'd5, 4'd6, 0, 0, w);

        // Stalled response with req1 waiting; req1 granted right after handshake.
        set_req(1, 1'b0, 3'b011, 4'd2, 4'd6);
        run_op(0, 3'b000, 4'd5, 4'hE, 5, 1, w);
        run_op(1, 3'b011, 4'd2, 4'd6, 0, 0, w);
        check("after_hs_wait", w, 0);

        // Reset during ISSUE: everything clears, pending req0 is re-granted.
        set_req(0, 1'b1, 3'b000, 4'd2, 4'd2);
        #1;
        check("pre_rst_ready", req0_ready, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", {req0_ready, req1_ready}, 0);
        check("mid_rst_alu", {alu_op, alu_a, alu_b}, 0);
        check("mid_rst_rsp", {rsp0_valid, rsp1_valid, rsp_r, rsp_ovf, rsp_err}, 0);
        check("mid_rst_last", {last_r, last_ovf, last_src}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        last_g = -1;
        run_op(0, 3'b000, 4'd2, 4'd2, 0, 0, w);
        check("regrant_wait", w, 0);

        // Randomized traffic against the round-robin model.
        pulse_reset();
        for (int it = 0; it < 40; it++) begin
            logic       v0, v1;
            logic [2:0] op;
            logic [3:0] a, b, la, lb;
            logic [2:0] lop;
            int         win, pref;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            op = 3'($urandom_range(0, 7)); a = 4'($urandom); b = 4'($urandom);
            lop = 3'($urandom_range(0, 7)); la = 4'($urandom); lb = 4'($urandom);
            pref = (last_g == 0) ? 1 : 0;
            win  = (v0 && v1) ? pref : (v1 ? 1 : 0);
            if (v0 && v1) set_req(1 - win, 1'b1, lop, la, lb);
            run_op(win, op, a, b, $urandom_range(0, 3), 0, w);
            check("rand_wait", w, 0);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
